// File: rtl/seq_mul_if.sv
// Request/response bundle for the sequential multiplier: operand handshake in,
// product handshake out.
interface seq_mul_if #(
    parameter int N = 16
);
    logic           in_valid;
    logic           in_ready;
    logic           in_signed;
    logic [N-1:0]   input1;
    logic [N-1:0]   input2;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] mul_o;

    modport master (
        output in_valid, in_signed, input1, input2, out_ready,
        input  in_ready, out_valid, mul_o
    );

    modport slave (
        input  in_valid, in_signed, input1, input2, out_ready,
        output in_ready, out_valid, mul_o
    );
endinterface

// File: rtl/seq_mul.sv
// Shift-add multiplier, one multiplier bit per cycle, signed via magnitude + sign fix.
// Define SEQ_MUL_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
module seq_mul #(
    parameter int N = 16
) (
    input  logic     clk,
    input  logic     rst,
    seq_mul_if.slave bus,
    output logic     busy
);
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2*N-1:0]   mcand_q, mcand_d;
    logic [N-1:0]     mplier_q, mplier_d;
    logic [2*N-1:0]   acc_q, acc_d;
    logic             neg_q, neg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*N-1:0]   mul_q, mul_d;

    logic [N-1:0]     mag1, mag2;
    logic [2*N-1:0]   acc_sum;
    logic [CNT_W-1:0] cnt_inc;
    logic             last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            mul_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            mul_q    <= mul_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        mul_d    = mul_q;

        // An N-bit unsigned magnitude holds 2^(N-1) for the most negative operand.
        mag1 = (bus.in_signed && bus.input1[N-1]) ? (~bus.input1 + 1'b1) : bus.input1;
        mag2 = (bus.in_signed && bus.input2[N-1]) ? (~bus.input2 + 1'b1) : bus.input2;

        acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
        cnt_inc = cnt_q + CNT_W'(1);
        last    = (cnt_inc == CNT_W'(N));
`ifdef SEQ_MUL_EARLY_TERM_EN
        last    = last || (mplier_q[N-1:1] == '0);
`endif

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    mcand_d  = {{N{1'b0}}, mag1};
                    mplier_d = mag2;
                    neg_d    = bus.in_signed & (bus.input1[N-1] ^ bus.input2[N-1]);
                    cnt_d    = '0;
                    acc_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_inc;
                if (last) begin
                    mul_d   = neg_q ? -acc_sum : acc_sum;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.mul_o     = mul_q;
    assign busy          = (state_q == BUSY);
endmodule
